// File: rtl/gpio_walk_checker.sv
// Debounced walking-one checker for a 48-pin GPIO loopback header.
// Define GPIO_TIMEOUT_EN to add a TRACK-state watchdog.
module gpio_walk_checker #(
    parameter int unsigned STABLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 134217728
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [47:0] gpio_i,
    input  logic        clr_i,
    output logic [5:0]  idx_o,
    output logic        valid_o,
    output logic        step_o,
    output logic [15:0] good_cnt_o,
    output logic [15:0] err_cnt_o,
    output logic        err_o
);

    typedef enum logic [1:0] {C_ZERO, C_ONE, C_MULTI} cls_e;
    typedef enum logic {ACQUIRE, TRACK} state_e;

    localparam logic [7:0] STAB = 8'(STABLE_CYCLES);
    localparam logic [5:0] NONE = 6'h3F;

    logic [47:0] sync1_q, sync2_q;
    cls_e        cls_c, cls_q;
    logic [5:0]  pos_c, pos_q;
    logic [7:0]  stab_q;
    logic        taken_q;
    logic        changed, accept;
    logic        acc_zero, acc_one, acc_multi;
    logic        wd_fire;

    state_e      state_q, state_d;
    logic [5:0]  last_q, last_d;
    logic [5:0]  idx_d;
    logic        valid_d, step_d, err_d;
    logic [15:0] good_d, errc_d, good_inc, errc_inc;
    logic [5:0]  next_exp;

    always_comb begin
        pos_c = '0;
        for (int i = 0; i < 48; i++) begin
            if (sync2_q[i]) pos_c = 6'(i);
        end
        if (sync2_q == '0) begin
            cls_c = C_ZERO;
        end else if ((sync2_q & (sync2_q - 48'd1)) == '0) begin
            cls_c = C_ONE;
        end else begin
            cls_c = C_MULTI;
        end
    end

    // A one-hot with a different position is a new run as well
    assign changed = (cls_c != cls_q) ||
                     (cls_c == C_ONE && pos_c != pos_q);
    assign accept    = (stab_q == STAB) && !taken_q;
    assign acc_zero  = accept && cls_q == C_ZERO;
    assign acc_one   = accept && cls_q == C_ONE;
    assign acc_multi = accept && cls_q == C_MULTI;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cls_q   <= C_ZERO;
            pos_q   <= '0;
            stab_q  <= '0;
            taken_q <= 1'b0;
        end else begin
            sync1_q <= gpio_i;
            sync2_q <= sync1_q;
            cls_q   <= cls_c;
            pos_q   <= pos_c;
            if (changed) begin
                stab_q  <= 8'd1;
                taken_q <= 1'b0;
            end else begin
                if (stab_q != 8'hFF) stab_q <= stab_q + 8'd1;
                if (accept) taken_q <= 1'b1;
            end
        end
    end

`ifdef GPIO_TIMEOUT_EN
    localparam logic [27:0] WD_LAST = 28'(TIMEOUT_CYCLES - 1);
    logic [27:0] wd_q;

    assign wd_fire = state_q == TRACK && !acc_one && wd_q == WD_LAST;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wd_q <= '0;
        end else if (state_q != TRACK || acc_one || wd_fire) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_q + 28'd1;
        end
    end
`else
    // Never true for a legal TIMEOUT_CYCLES: no watchdog in this build
    assign wd_fire = (TIMEOUT_CYCLES == 0);
`endif

    assign good_inc = (good_cnt_o == 16'hFFFF) ? good_cnt_o : good_cnt_o + 16'd1;
    assign errc_inc = (err_cnt_o == 16'hFFFF) ? err_cnt_o : err_cnt_o + 16'd1;
    assign next_exp = (last_q == 6'd47) ? 6'd0 : last_q + 6'd1;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        idx_d   = idx_o;
        valid_d = valid_o;
        step_d  = 1'b0;
        good_d  = good_cnt_o;
        errc_d  = err_cnt_o;
        err_d   = err_o;
        unique case (1'b1)
            acc_zero: begin
                idx_d   = NONE;
                valid_d = 1'b0;
            end
            acc_one: begin
                if (state_q == TRACK) begin
                    if (pos_q == next_exp) begin
                        good_d = good_inc;
                    end else begin
                        errc_d = errc_inc;
                        err_d  = 1'b1;
                    end
                end
                state_d = TRACK;
                last_d  = pos_q;
                idx_d   = pos_q;
                valid_d = 1'b1;
                step_d  = 1'b1;
            end
            acc_multi: begin
                errc_d  = errc_inc;
                err_d   = 1'b1;
                idx_d   = NONE;
                valid_d = 1'b0;
                state_d = ACQUIRE;
            end
            default: ;
        endcase
        if (wd_fire) begin
            errc_d  = errc_inc;
            err_d   = 1'b1;
            state_d = ACQUIRE;
        end
        if (clr_i) begin
            good_d = '0;
            errc_d = '0;
            err_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ACQUIRE;
            last_q     <= '0;
            idx_o      <= NONE;
            valid_o    <= 1'b0;
            step_o     <= 1'b0;
            good_cnt_o <= '0;
            err_cnt_o  <= '0;
            err_o      <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            idx_o      <= idx_d;
            valid_o    <= valid_d;
            step_o     <= step_d;
            good_cnt_o <= good_d;
            err_cnt_o  <= errc_d;
            err_o      <= err_d;
        end
    end

endmodule
